// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: state encoding, WB control
// bit positions and the default data width.
// No logic; imported by mem_access_stage and its sub-module.
package mem_access_stage_pkg;

    localparam int DATA_W_DEF = 16;

    // 2-bit state encoding of the access FSM
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_WR_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_RD_WAIT = ST_RD_WAIT,
        S_WR_WAIT = ST_WR_WAIT,
        S_DONE    = ST_DONE
    } state_t;

    // Bit positions inside the {RegWrite, MemtoReg} WB control pair
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

endpackage

// File: rtl/mem_access_stage_sat_counter.sv
// Purpose: saturating up-counter, counts cycles where en=1, sticks at all ones.
// Latency: count reflects en one clock later.
// Backpressure: none; en is sampled every clock.
// Ports: clk, rst_n (async active-low), en, count[CNT_W-1:0].
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Purpose: MEM stage; runs a data-memory load/store with ready handshake.
// Latency: >=3 cycles per memory op (issue, >=1 wait, DONE); non-memory ops pass through in 0.
// Backpressure: mem_stall freezes upstream while the access is outstanding; WB pair gated to 00.
// Ports: EX/MEM inputs (MEM_*), data bus (d_*), mem_stall, WB_forwarded,
//        MEM_ReadDataOfMem, mem_timeout pulse, saturating stall_count.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              MEM_valid,
    input  logic              MEM_MemRead,
    input  logic              MEM_MemWrite,
    input  logic [DATA_W-1:0] MEM_ALUResult,
    input  logic [DATA_W-1:0] MEM_WriteData,
    input  logic [1:0]        MEM_WB,
    output logic              d_readM,
    output logic              d_writeM,
    output logic [DATA_W-1:0] d_address,
    output logic [DATA_W-1:0] d_wdata,
    input  logic [DATA_W-1:0] d_rdata,
    input  logic              d_ready,
    output logic              mem_stall,
    output logic [1:0]        WB_forwarded,
    output logic [DATA_W-1:0] MEM_ReadDataOfMem,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WC_W-1:0]   r_wait_cnt;
    logic [DATA_W-1:0] r_rdata_q;
    logic              r_timeout;
    logic              w_req;
    logic              w_wait_last;
    logic              w_abort;
    logic              w_in_wait;

    assign w_req       = MEM_valid & (MEM_MemRead | MEM_MemWrite);
    assign w_wait_last = (r_wait_cnt == WC_W'(TIMEOUT - 1));
    assign w_in_wait   = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        d_readM     = 1'b0;
        d_writeM    = 1'b0;
        mem_stall   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Request goes out combinationally in the same cycle; a
                // simultaneous read+write is performed as a write.
                if (w_req) begin
                    mem_stall = 1'b1;
                    if (MEM_MemWrite) begin
                        d_writeM    = 1'b1;
                        w_state_nxt = S_WR_WAIT;
                    end else begin
                        d_readM     = 1'b1;
                        w_state_nxt = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT, S_WR_WAIT: begin
                mem_stall = 1'b1;
                d_readM   = (r_state == S_RD_WAIT);
                d_writeM  = (r_state == S_WR_WAIT);
                if (d_ready) begin
                    w_state_nxt = S_DONE;
                end else if (w_wait_last) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                // DONE: EX/MEM still shows the finished instruction, so req is ignored
                w_state_nxt = S_IDLE;
            end
        endcase
        // Async reset must drop the bus request and stall immediately,
        // even if EX/MEM still presents a memory op while in IDLE.
        if (!reset_n) begin
            d_readM   = 1'b0;
            d_writeM  = 1'b0;
            mem_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
            r_rdata_q  <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_abort;
            if (w_in_wait && !d_ready && !w_wait_last) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
            if ((r_state == S_RD_WAIT) && d_ready) begin
                r_rdata_q <= d_rdata;
            end else if (w_abort) begin
                r_rdata_q <= {DATA_W{1'b1}};
            end
        end
    end

    assign d_address         = (d_readM | d_writeM) ? MEM_ALUResult : '0;
    assign d_wdata           = d_writeM ? MEM_WriteData : '0;
    assign MEM_ReadDataOfMem = r_rdata_q;
    assign mem_timeout       = r_timeout;

    // MEM/WB latches every clock, so a stalled cycle must present a bubble
    always_comb begin
        WB_forwarded = MEM_WB;
        if (mem_stall) begin
            WB_forwarded[WB_REGWRITE] = 1'b0;
            WB_forwarded[WB_MEMTOREG] = 1'b0;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (mem_stall),
        .count (stall_count)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed memory ops against a transaction-level
// model (outstanding access, waits so far, completion cycle), compared every
// negative clock edge, plus hand-computed literal expectations.
module tb_mem_access_stage;

    localparam int DW = 16;
    localparam int TO = 15;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          MEM_valid, MEM_MemRead, MEM_MemWrite;
    logic [DW-1:0] MEM_ALUResult, MEM_WriteData;
    logic [1:0]    MEM_WB;
    logic          d_readM, d_writeM;
    logic [DW-1:0] d_address, d_wdata, d_rdata;
    logic          d_ready;
    logic          mem_stall;
    logic [1:0]    WB_forwarded;
    logic [DW-1:0] MEM_ReadDataOfMem;
    logic          mem_timeout;
    logic [CW-1:0] stall_count;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DATA_W  (DW),
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .MEM_valid         (MEM_valid),
        .MEM_MemRead       (MEM_MemRead),
        .MEM_MemWrite      (MEM_MemWrite),
        .MEM_ALUResult     (MEM_ALUResult),
        .MEM_WriteData     (MEM_WriteData),
        .MEM_WB            (MEM_WB),
        .d_readM           (d_readM),
        .d_writeM          (d_writeM),
        .d_address         (d_address),
        .d_wdata           (d_wdata),
        .d_rdata           (d_rdata),
        .d_ready           (d_ready),
        .mem_stall         (mem_stall),
        .WB_forwarded      (WB_forwarded),
        .MEM_ReadDataOfMem (MEM_ReadDataOfMem),
        .mem_timeout       (mem_timeout),
        .stall_count       (stall_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy   = 0;   // access issued and not yet finished
    bit          m_wr     = 0;   // outstanding access is a write
    bit          m_done   = 0;   // this cycle is the completion cycle
    int          m_waits  = 0;   // wait cycles spent so far
    logic [DW-1:0] m_data = '0;
    bit          m_to     = 0;
    int          m_stalls = 0;

    bit            e_req, e_issue, e_stall, e_rd, e_wr;
    logic [DW-1:0] e_addr, e_wdat;
    logic [1:0]    e_wb;

    function automatic void calc();
        e_req   = reset_n && MEM_valid && (MEM_MemRead || MEM_MemWrite);
        e_issue = !m_busy && !m_done && e_req;
        e_stall = reset_n && (e_issue || m_busy);
        e_wr    = reset_n && ((e_issue && MEM_MemWrite) || (m_busy && m_wr));
        e_rd    = reset_n && ((e_issue && !MEM_MemWrite) || (m_busy && !m_wr));
        e_addr  = (e_rd || e_wr) ? MEM_ALUResult : '0;
        e_wdat  = e_wr ? MEM_WriteData : '0;
        e_wb    = e_stall ? 2'b00 : MEM_WB;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_wr = 0; m_done = 0; m_waits = 0;
            m_data = '0; m_to = 0; m_stalls = 0;
        end else begin
            calc();
            if (e_stall && m_stalls < SAT) m_stalls++;
            m_to = 0;
            if (m_done) begin
                m_done = 0;
            end else if (e_issue) begin
                m_busy  = 1;
                m_wr    = MEM_MemWrite;
                m_waits = 0;
            end else if (m_busy) begin
                m_waits++;
                if (d_ready) begin
                    m_busy = 0;
                    m_done = 1;
                    if (!m_wr) m_data = d_rdata;
                end else if (m_waits == TO) begin
                    m_busy = 0;
                    m_done = 1;
                    m_data = '1;
                    m_to   = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        calc();
        chk("d_readM",      {31'd0, d_readM},      {31'd0, e_rd});
        chk("d_writeM",     {31'd0, d_writeM},     {31'd0, e_wr});
        chk("d_address",    32'(d_address),        32'(e_addr));
        chk("d_wdata",      32'(d_wdata),          32'(e_wdat));
        chk("mem_stall",    {31'd0, mem_stall},    {31'd0, e_stall});
        chk("WB_forwarded", 32'(WB_forwarded),     32'(e_wb));
        chk("rdata",        32'(MEM_ReadDataOfMem), 32'(m_data));
        chk("mem_timeout",  {31'd0, mem_timeout},  {31'd0, m_to});
        chk("stall_count",  32'(stall_count),      32'(m_stalls));
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input bit v, input bit rd, input bit wr, input logic [DW-1:0] alu,
                          input logic [DW-1:0] wd, input logic [1:0] wb, input bit rdy,
                          input logic [DW-1:0] rdat);
        MEM_valid = v; MEM_MemRead = rd; MEM_MemWrite = wr;
        MEM_ALUResult = alu; MEM_WriteData = wd; MEM_WB = wb;
        d_ready = rdy; d_rdata = rdat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        set_in(0, 0, 0, '0, '0, 2'b00, 0, '0);
        tick();
        @(negedge clk);
        chk("rst stall_count", 32'(stall_count), 32'd0);
        chk("rst rdata", 32'(MEM_ReadDataOfMem), 32'd0);
        chk("rst bus", {30'd0, d_readM, d_writeM}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // non-memory op passes straight through
        set_in(1, 0, 0, 16'h0055, '0, 2'b10, 0, '0);
        @(negedge clk);
        chk("nonmem stall", {31'd0, mem_stall}, 32'd0);
        chk("nonmem wb", 32'(WB_forwarded), 32'h2);
        tick();

        // load 0x0040, ready on second wait cycle with 0xBEEF
        set_in(1, 1, 0, 16'h0040, '0, 2'b11, 0, '0);
        @(negedge clk);
        chk("ld issue readM", {31'd0, d_readM}, 32'd1);
        chk("ld issue addr", 32'(d_address), 32'h40);
        chk("ld issue wb", 32'(WB_forwarded), 32'h0);
        tick();
        tick();
        set_in(1, 1, 0, 16'h0040, '0, 2'b11, 1, 16'hBEEF);
        tick();
        set_in(1, 1, 0, 16'h0040, '0, 2'b11, 0, 16'h0000);
        @(negedge clk);
        chk("ld done data", 32'(MEM_ReadDataOfMem), 32'hBEEF);
        chk("ld done wb", 32'(WB_forwarded), 32'h3);
        chk("ld done stall_count", 32'(stall_count), 32'd3);
        tick();

        // store 0x1234 to 0x0010, ready on first wait cycle
        set_in(1, 0, 1, 16'h0010, 16'h1234, 2'b00, 0, '0);
        @(negedge clk);
        chk("st issue wdata", 32'(d_wdata), 32'h1234);
        tick();
        set_in(1, 0, 1, 16'h0010, 16'h1234, 2'b00, 1, '0);
        @(negedge clk);
        chk("st wait writeM", {31'd0, d_writeM}, 32'd1);
        tick();
        set_in(1, 0, 1, 16'h0010, 16'h1234, 2'b00, 0, '0);
        @(negedge clk);
        chk("st done writeM", {31'd0, d_writeM}, 32'd0);
        tick();

        // load that never gets ready -> abort after TO wait cycles
        set_in(1, 1, 0, 16'h0020, '0, 2'b11, 0, '0);
        tick();
        for (int i = 0; i < TO; i++) tick();
        @(negedge clk);
        chk("to pulse", {31'd0, mem_timeout}, 32'd1);
        chk("to data", 32'(MEM_ReadDataOfMem), 32'hFFFF);
        chk("to stall_count sat", 32'(stall_count), 32'(SAT));
        tick();
        set_in(0, 0, 0, '0, '0, 2'b00, 0, '0);
        @(negedge clk);
        chk("to pulse end", {31'd0, mem_timeout}, 32'd0);
        tick();

        // rd=wr=1 -> treated as write; ready data must not be captured
        set_in(1, 1, 1, 16'h0030, 16'hA5A5, 2'b00, 0, '0);
        @(negedge clk);
        chk("rdwr readM", {31'd0, d_readM}, 32'd0);
        chk("rdwr writeM", {31'd0, d_writeM}, 32'd1);
        tick();
        set_in(1, 1, 1, 16'h0030, 16'hA5A5, 2'b00, 1, 16'h7777);
        tick();
        set_in(1, 1, 1, 16'h0030, 16'hA5A5, 2'b00, 0, '0);
        @(negedge clk);
        chk("rdwr data kept", 32'(MEM_ReadDataOfMem), 32'hFFFF);
        tick();

        // back-to-back loads: no re-issue in DONE
        set_in(1, 1, 0, 16'h0100, '0, 2'b11, 0, '0);
        tick();
        set_in(1, 1, 0, 16'h0100, '0, 2'b11, 1, 16'h1111);
        tick();
        set_in(1, 1, 0, 16'h0100, '0, 2'b11, 0, '0);
        @(negedge clk);
        chk("b2b done no reissue", {31'd0, d_readM}, 32'd0);
        chk("b2b first data", 32'(MEM_ReadDataOfMem), 32'h1111);
        tick();
        set_in(1, 1, 0, 16'h0102, '0, 2'b11, 0, '0);
        @(negedge clk);
        chk("b2b second issue addr", 32'(d_address), 32'h102);
        tick();
        set_in(1, 1, 0, 16'h0102, '0, 2'b11, 1, 16'h2222);
        tick();
        set_in(0, 0, 0, '0, '0, 2'b00, 0, '0);
        @(negedge clk);
        chk("b2b second data", 32'(MEM_ReadDataOfMem), 32'h2222);
        tick();

        // reset asserted during RD_WAIT
        set_in(1, 1, 0, 16'h0200, '0, 2'b11, 0, '0);
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("rst mid readM", {31'd0, d_readM}, 32'd0);
        chk("rst mid stall", {31'd0, mem_stall}, 32'd0);
        tick();
        set_in(0, 0, 0, '0, '0, 2'b00, 0, '0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst mid count", 32'(stall_count), 32'd0);
        tick();

        // a fresh load after reset
        set_in(1, 1, 0, 16'h0300, '0, 2'b01, 0, '0);
        tick();
        set_in(1, 1, 0, 16'h0300, '0, 2'b01, 1, 16'h3C3C);
        tick();
        set_in(1, 1, 0, 16'h0300, '0, 2'b01, 0, '0);
        @(negedge clk);
        chk("post rst data", 32'(MEM_ReadDataOfMem), 32'h3C3C);
        tick();
        set_in(0, 0, 0, '0, '0, 2'b00, 0, '0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
